// File: rtl/matrix_loader.sv
// matrix_loader: assembles big-endian 16-bit words from a host byte stream and
// writes matrix A then matrix B row-major into the shared data memory, then
// pulses new_data to start the systolic array.
//
// Byte handshake: a byte moves only in a cycle where rx_valid && rx_ready are
// both high at the rising edge; rx_ready is a registered flag that is high only
// in RX_HI/RX_LO, and rx_valid may drop for any number of cycles without loss.
module matrix_loader #(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_start,
  input  logic [11:0]             addr_A,
  input  logic [11:0]             addr_B,
  input  logic [8:0]              n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  output logic [11:0]             mem_addr,
  output logic signed [WIDTH-1:0] mem_data,
  output logic                    mem_wren,
  output logic                    busy,
  output logic                    new_data,
  output logic                    load_error,
  output logic [17:0]             words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_RX_HI, S_RX_LO, S_WRITE, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [11:0]      addr_a_q, addr_a_d;
  logic [11:0]      addr_b_q, addr_b_d;
  logic [8:0]       n_q, n_d;
  logic [17:0]      nn_q, nn_d;
  logic [7:0]       hi_q, hi_d;
  logic [11:0]      mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0] mem_data_q, mem_data_d;
  logic             load_error_q, load_error_d;
  logic [17:0]      words_q, words_d;
  logic             rx_ready_q, rx_ready_d;
  logic             mem_wren_q, mem_wren_d;
  logic             busy_q, busy_d;
  logic             new_data_q, new_data_d;

  logic [18:0]      end_a, end_b, total_words;
  logic             params_bad;
  logic             last_word;
  logic [11:0]      word_addr;

  // Parameter validation and word-address generation from latched values
  always_comb begin
    end_a       = {7'd0, addr_a_q} + {1'b0, nn_q};
    end_b       = {7'd0, addr_b_q} + {1'b0, nn_q};
    total_words = {nn_q, 1'b0};
    // Regions [A, A+nn) and [B, B+nn) overlap when each starts before the other ends
    params_bad  = (n_q == 9'd0) ||
                  (end_a > 19'd4096) || (end_b > 19'd4096) ||
                  (({7'd0, addr_a_q} < end_b) && ({7'd0, addr_b_q} < end_a));
    last_word   = (({1'b0, words_q} + 19'd1) == total_words);
    // 12-bit modular arithmetic is exact here because CHECK rejects wrapping
    if (words_q < nn_q) word_addr = addr_a_q + words_q[11:0];
    else                word_addr = addr_b_q + (words_q[11:0] - nn_q[11:0]);
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    addr_a_d     = addr_a_q;
    addr_b_d     = addr_b_q;
    n_d          = n_q;
    nn_d         = nn_q;
    hi_d         = hi_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    load_error_d = load_error_q;
    words_d      = words_q;
    unique case (state_q)
      S_IDLE: begin
        if (load_start) begin
          addr_a_d     = addr_A;
          addr_b_d     = addr_B;
          n_d          = n;
          nn_d         = {9'd0, n} * {9'd0, n};
          load_error_d = 1'b0;
          words_d      = 18'd0;
          state_d      = S_CHECK;
        end
      end
      S_CHECK: begin
        if (params_bad) begin
          load_error_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          state_d      = S_RX_HI;
        end
      end
      S_RX_HI: begin
        if (rx_valid && rx_ready_q) begin
          hi_d    = rx_data;
          state_d = S_RX_LO;
        end
      end
      S_RX_LO: begin
        if (rx_valid && rx_ready_q) begin
          mem_data_d = {hi_q, rx_data};
          mem_addr_d = word_addr;
          state_d    = S_WRITE;
        end
      end
      S_WRITE: begin
        words_d = words_q + 18'd1;
        state_d = last_word ? S_DONE : S_RX_HI;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Status flags are registered decodes of the next state
    rx_ready_d = (state_d == S_RX_HI) || (state_d == S_RX_LO);
    mem_wren_d = (state_d == S_WRITE);
    busy_d     = (state_d != S_IDLE);
    new_data_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_a_q     <= 12'd0;
      addr_b_q     <= 12'd0;
      n_q          <= 9'd0;
      nn_q         <= 18'd0;
      hi_q         <= 8'd0;
      mem_addr_q   <= 12'd0;
      mem_data_q   <= '0;
      load_error_q <= 1'b0;
      words_q      <= 18'd0;
      rx_ready_q   <= 1'b0;
      mem_wren_q   <= 1'b0;
      busy_q       <= 1'b0;
      new_data_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_a_q     <= addr_a_d;
      addr_b_q     <= addr_b_d;
      n_q          <= n_d;
      nn_q         <= nn_d;
      hi_q         <= hi_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      load_error_q <= load_error_d;
      words_q      <= words_d;
      rx_ready_q   <= rx_ready_d;
      mem_wren_q   <= mem_wren_d;
      busy_q       <= busy_d;
      new_data_q   <= new_data_d;
    end
  end

  assign rx_ready     = rx_ready_q;
  assign mem_addr     = mem_addr_q;
  assign mem_data     = mem_data_q;
  assign mem_wren     = mem_wren_q;
  assign busy         = busy_q;
  assign new_data     = new_data_q;
  assign load_error   = load_error_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_matrix_loader.sv
// tb_matrix_loader: directed scenarios for matrix_loader with a falling-edge
// memory model and constant expected values.
module tb_matrix_loader;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               load_start = 1'b0;
  logic [11:0]        addr_A = 12'd0;
  logic [11:0]        addr_B = 12'd0;
  logic [8:0]         n = 9'd0;
  logic [7:0]         rx_data = 8'd0;
  logic               rx_valid = 1'b0;
  logic               rx_ready;
  logic [11:0]        mem_addr;
  logic signed [15:0] mem_data;
  logic               mem_wren, busy, new_data, load_error;
  logic [17:0]        words_loaded;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int wren_cnt = 0, nd_cnt = 0, viol_cnt = 0, last_wren_cyc = 0, nd_cyc = 0;
  logic [15:0] mem [0:4095];
  logic [7:0]  tx_bytes [0:63];

  matrix_loader #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .load_start(load_start),
    .addr_A(addr_A), .addr_B(addr_B), .n(n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
    .busy(busy), .new_data(new_data), .load_error(load_error),
    .words_loaded(words_loaded)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Falling-edge memory and pulse monitor
  always @(negedge clk) begin
    if (mem_wren === 1'b1) begin
      mem[mem_addr] = mem_data;
      wren_cnt++;
      last_wren_cyc = cyc;
      if (rx_ready !== 1'b0) viol_cnt++;
    end
    if (new_data === 1'b1) begin
      nd_cnt++;
      nd_cyc = cyc;
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    foreach (mem[i]) mem[i] = 16'hDEAD;
    wren_cnt = 0; nd_cnt = 0; viol_cnt = 0; last_wren_cyc = 0; nd_cyc = 0;
  endtask

  task automatic start_load(input logic [11:0] a, input logic [11:0] b,
                            input logic [8:0] nv, output int acc);
    addr_A = a; addr_B = b; n = nv; load_start = 1'b1;
    tick();
    load_start = 1'b0;
    acc = cyc;
  endtask

  task automatic feed(input int nbytes, input bit rnd);
    int idx = 0;
    int guard = 0;
    while (idx < nbytes && guard < 1000) begin
      rx_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      rx_data  = tx_bytes[idx];
      if (rx_valid && rx_ready) idx++;
      tick();
      guard++;
    end
    rx_valid = 1'b0;
    n_cmp++; if (idx !== nbytes) begin n_fail++; $display("FAIL feed_timeout: sent %0d bytes, required %0d", idx, nbytes); end
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (busy !== 1'b0 && guard < 200) begin tick(); guard++; end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_timeout: busy=%b required 0", busy); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_cmp++; if ({rx_ready, mem_wren, busy, new_data, load_error} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b required 00000", {rx_ready, mem_wren, busy, new_data, load_error}); end
    n_cmp++; if (mem_addr !== 12'h000) begin n_fail++; $display("FAIL reset_mem_addr: got %h required 000", mem_addr); end
    n_cmp++; if (mem_data !== 16'h0000) begin n_fail++; $display("FAIL reset_mem_data: got %h required 0000", mem_data); end
    n_cmp++; if (words_loaded !== 18'd0) begin n_fail++; $display("FAIL reset_words: got %0d required 0", words_loaded); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int acc;
    clear_all();
    for (int i = 0; i < 8; i++) begin tx_bytes[2*i] = 8'h00; tx_bytes[2*i+1] = 8'(i + 1); end
    start_load(12'h000, 12'h010, 9'd2, acc);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_check: got %b required 1", busy); end
    n_cmp++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_check: got %b required 0", rx_ready); end
    feed(16, 1'b0);
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (mem[i] !== 16'(i + 1)) begin n_fail++; $display("FAIL basic_mem_a[%0d]: got %h required %h", i, mem[i], 16'(i + 1)); end
      n_cmp++; if (mem[16 + i] !== 16'(i + 5)) begin n_fail++; $display("FAIL basic_mem_b[%0d]: got %h required %h", i, mem[16 + i], 16'(i + 5)); end
    end
    n_cmp++; if (wren_cnt !== 8) begin n_fail++; $display("FAIL basic_wren_count: got %0d required 8", wren_cnt); end
    n_cmp++; if (words_loaded !== 18'd8) begin n_fail++; $display("FAIL basic_words: got %0d required 8", words_loaded); end
    n_cmp++; if (nd_cnt !== 1) begin n_fail++; $display("FAIL basic_new_data_count: got %0d required 1", nd_cnt); end
    n_cmp++; if (nd_cyc !== last_wren_cyc + 1) begin n_fail++; $display("FAIL basic_new_data_timing: got cycle %0d required %0d", nd_cyc, last_wren_cyc + 1); end
    n_cmp++; if (nd_cyc !== acc + 25) begin n_fail++; $display("FAIL basic_total_latency: got cycle %0d required %0d", nd_cyc, acc + 25); end
    n_cmp++; if (load_error !== 1'b0) begin n_fail++; $display("FAIL basic_error: got %b required 0", load_error); end
  endtask

  task automatic test_backpressure();
    int acc;
    clear_all();
    for (int i = 0; i < 8; i++) begin tx_bytes[2*i] = 8'h00; tx_bytes[2*i+1] = 8'(i + 1); end
    start_load(12'h000, 12'h010, 9'd2, acc);
    feed(16, 1'b1);
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (mem[i] !== 16'(i + 1)) begin n_fail++; $display("FAIL bp_mem_a[%0d]: got %h required %h", i, mem[i], 16'(i + 1)); end
      n_cmp++; if (mem[16 + i] !== 16'(i + 5)) begin n_fail++; $display("FAIL bp_mem_b[%0d]: got %h required %h", i, mem[16 + i], 16'(i + 5)); end
    end
    n_cmp++; if (wren_cnt !== 8) begin n_fail++; $display("FAIL bp_wren_count: got %0d required 8", wren_cnt); end
    n_cmp++; if (viol_cnt !== 0) begin n_fail++; $display("FAIL bp_ready_in_write: got %0d cycles required 0", viol_cnt); end
    n_cmp++; if (nd_cnt !== 1) begin n_fail++; $display("FAIL bp_new_data_count: got %0d required 1", nd_cnt); end
  endtask

  task automatic test_errors();
    int acc;
    clear_all();
    start_load(12'h000, 12'h010, 9'd0, acc);
    n_cmp++; if (words_loaded !== 18'd0) begin n_fail++; $display("FAIL err_words_cleared: got %0d required 0", words_loaded); end
    tick();
    n_cmp++; if (load_error !== 1'b1) begin n_fail++; $display("FAIL err_n0_flag: got %b required 1", load_error); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL err_n0_busy: got %b required 0", busy); end
    tick(); tick();
    n_cmp++; if (wren_cnt !== 0) begin n_fail++; $display("FAIL err_n0_wren: got %0d required 0", wren_cnt); end
    n_cmp++; if (nd_cnt !== 0) begin n_fail++; $display("FAIL err_n0_new_data: got %0d required 0", nd_cnt); end
    start_load(12'h000, 12'h002, 9'd2, acc);
    n_cmp++; if (load_error !== 1'b0) begin n_fail++; $display("FAIL err_flag_cleared: got %b required 0", load_error); end
    tick();
    n_cmp++; if (load_error !== 1'b1) begin n_fail++; $display("FAIL err_overlap: got %b required 1", load_error); end
    start_load(12'hFFD, 12'h000, 9'd2, acc);
    tick();
    n_cmp++; if (load_error !== 1'b1) begin n_fail++; $display("FAIL err_a_bound: got %b required 1", load_error); end
    n_cmp++; if (wren_cnt !== 0) begin n_fail++; $display("FAIL err_no_writes: got %0d required 0", wren_cnt); end
    // Top-of-memory boundary load is legal
    for (int i = 0; i < 8; i++) begin tx_bytes[2*i] = 8'hA0; tx_bytes[2*i+1] = 8'(i); end
    start_load(12'hFFC, 12'h000, 9'd2, acc);
    n_cmp++; if (load_error !== 1'b0) begin n_fail++; $display("FAIL edge_flag_cleared: got %b required 0", load_error); end
    feed(16, 1'b0);
    wait_idle();
    n_cmp++; if (mem[12'hFFC] !== 16'hA000) begin n_fail++; $display("FAIL edge_mem_ffc: got %h required a000", mem[12'hFFC]); end
    n_cmp++; if (mem[12'hFFF] !== 16'hA003) begin n_fail++; $display("FAIL edge_mem_fff: got %h required a003", mem[12'hFFF]); end
    n_cmp++; if (mem[12'h000] !== 16'hA004) begin n_fail++; $display("FAIL edge_mem_000: got %h required a004", mem[12'h000]); end
    n_cmp++; if (mem[12'h003] !== 16'hA007) begin n_fail++; $display("FAIL edge_mem_003: got %h required a007", mem[12'h003]); end
    n_cmp++; if (wren_cnt !== 8) begin n_fail++; $display("FAIL edge_wren_count: got %0d required 8", wren_cnt); end
    n_cmp++; if (load_error !== 1'b0) begin n_fail++; $display("FAIL edge_error: got %b required 0", load_error); end
    n_cmp++; if (nd_cnt !== 1) begin n_fail++; $display("FAIL edge_new_data_count: got %0d required 1", nd_cnt); end
  endtask

  task automatic test_signed();
    int acc;
    clear_all();
    tx_bytes[0] = 8'hFF; tx_bytes[1] = 8'hFE; tx_bytes[2] = 8'h80; tx_bytes[3] = 8'h00;
    start_load(12'h100, 12'h101, 9'd1, acc);
    feed(4, 1'b0);
    wait_idle();
    n_cmp++; if (mem[12'h100] !== 16'hFFFE) begin n_fail++; $display("FAIL signed_minus2: got %h required fffe", mem[12'h100]); end
    n_cmp++; if (mem[12'h101] !== 16'h8000) begin n_fail++; $display("FAIL signed_min: got %h required 8000", mem[12'h101]); end
    n_cmp++; if (words_loaded !== 18'd2) begin n_fail++; $display("FAIL signed_words: got %0d required 2", words_loaded); end
  endtask

  task automatic test_reset_mid();
    int acc;
    clear_all();
    for (int i = 0; i < 8; i++) begin tx_bytes[2*i] = 8'h01; tx_bytes[2*i+1] = 8'(i); end
    start_load(12'h020, 12'h030, 9'd2, acc);
    feed(6, 1'b0);
    tick();
    n_cmp++; if (wren_cnt !== 3) begin n_fail++; $display("FAIL rmid_pre_wren: got %0d required 3", wren_cnt); end
    n_cmp++; if (words_loaded !== 18'd3) begin n_fail++; $display("FAIL rmid_pre_words: got %0d required 3", words_loaded); end
    rst = 1'b1;
    tick();
    n_cmp++; if ({rx_ready, mem_wren, busy, new_data, load_error} !== 5'b0) begin n_fail++; $display("FAIL rmid_flags: got %b required 00000", {rx_ready, mem_wren, busy, new_data, load_error}); end
    n_cmp++; if (mem_addr !== 12'h000) begin n_fail++; $display("FAIL rmid_mem_addr: got %h required 000", mem_addr); end
    n_cmp++; if (mem_data !== 16'h0000) begin n_fail++; $display("FAIL rmid_mem_data: got %h required 0000", mem_data); end
    n_cmp++; if (words_loaded !== 18'd0) begin n_fail++; $display("FAIL rmid_words: got %0d required 0", words_loaded); end
    rst = 1'b0;
    tick(); tick();
    n_cmp++; if (nd_cnt !== 0) begin n_fail++; $display("FAIL rmid_no_new_data: got %0d required 0", nd_cnt); end
    clear_all();
    for (int i = 0; i < 8; i++) begin tx_bytes[2*i] = 8'(8'h10 + i); tx_bytes[2*i+1] = 8'(8'hC0 + i); end
    start_load(12'h040, 12'h050, 9'd2, acc);
    n_cmp++; if (words_loaded !== 18'd0) begin n_fail++; $display("FAIL rmid_restart_words: got %0d required 0", words_loaded); end
    feed(16, 1'b0);
    wait_idle();
    n_cmp++; if (mem[12'h040] !== 16'h10C0) begin n_fail++; $display("FAIL rmid_mem_40: got %h required 10c0", mem[12'h040]); end
    n_cmp++; if (mem[12'h043] !== 16'h13C3) begin n_fail++; $display("FAIL rmid_mem_43: got %h required 13c3", mem[12'h043]); end
    n_cmp++; if (mem[12'h050] !== 16'h14C4) begin n_fail++; $display("FAIL rmid_mem_50: got %h required 14c4", mem[12'h050]); end
    n_cmp++; if (mem[12'h053] !== 16'h17C7) begin n_fail++; $display("FAIL rmid_mem_53: got %h required 17c7", mem[12'h053]); end
    n_cmp++; if (words_loaded !== 18'd8) begin n_fail++; $display("FAIL rmid_final_words: got %0d required 8", words_loaded); end
    n_cmp++; if (nd_cnt !== 1) begin n_fail++; $display("FAIL rmid_new_data_count: got %0d required 1", nd_cnt); end
  endtask

  task automatic test_ignored_start();
    int acc;
    clear_all();
    for (int i = 0; i < 8; i++) begin tx_bytes[2*i] = 8'(8'h20 + i); tx_bytes[2*i+1] = 8'(8'h40 + i); end
    start_load(12'h060, 12'h070, 9'd2, acc);
    fork
      feed(16, 1'b0);
      begin
        repeat (5) tick();
        addr_A = 12'h200; addr_B = 12'h300; n = 9'd3; load_start = 1'b1;
        tick();
        load_start = 1'b0;
      end
    join
    wait_idle();
    n_cmp++; if (wren_cnt !== 8) begin n_fail++; $display("FAIL ign_wren_count: got %0d required 8", wren_cnt); end
    n_cmp++; if (mem[12'h060] !== 16'h2040) begin n_fail++; $display("FAIL ign_mem_60: got %h required 2040", mem[12'h060]); end
    n_cmp++; if (mem[12'h063] !== 16'h2343) begin n_fail++; $display("FAIL ign_mem_63: got %h required 2343", mem[12'h063]); end
    n_cmp++; if (mem[12'h070] !== 16'h2444) begin n_fail++; $display("FAIL ign_mem_70: got %h required 2444", mem[12'h070]); end
    n_cmp++; if (mem[12'h073] !== 16'h2747) begin n_fail++; $display("FAIL ign_mem_73: got %h required 2747", mem[12'h073]); end
    n_cmp++; if (mem[12'h200] !== 16'hDEAD) begin n_fail++; $display("FAIL ign_mem_200: got %h required dead", mem[12'h200]); end
    n_cmp++; if (load_error !== 1'b0) begin n_fail++; $display("FAIL ign_error: got %b required 0", load_error); end
    n_cmp++; if (words_loaded !== 18'd8) begin n_fail++; $display("FAIL ign_words: got %0d required 8", words_loaded); end
    n_cmp++; if (nd_cnt !== 1) begin n_fail++; $display("FAIL ign_new_data_count: got %0d required 1", nd_cnt); end
    tick(); tick(); tick();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_stays_idle: got %b required 0", busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_errors();
    test_signed();
    test_reset_mid();
    test_ignored_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_loader.md
# matrix_loader

Host-side loader that sits directly upstream of the systolic array top level. It receives a byte stream from the host link, assembles signed 16-bit words, and writes matrix A then matrix B row-major into the shared data memory at the caller-supplied base addresses. When the last word is written, it pulses `new_data` for one cycle to start the systolic computation. It is the only memory writer while the array is idle; the array reads the same memory afterwards.

## Interface
Parameters:
- `WIDTH`, 16: memory word width. Fixed at 16; each word is exactly two bytes.

Ports:
- `clk` in 1: single clock. Memory samples on the falling edge; all loader outputs are registered on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `load_start` in 1: one-cycle request. `addr_A`, `addr_B` and `n` are sampled when it is accepted.
- `addr_A` in 12: unsigned base address of matrix A.
- `addr_B` in 12: unsigned base address of matrix B.
- `n` in 9: unsigned matrix dimension; each matrix holds n*n words.
- `rx_data` in 8: host byte.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: loader accepts a byte this cycle.
- `mem_addr` out 12: memory write address.
- `mem_data` out WIDTH: memory write data, signed.
- `mem_wren` out 1: memory write enable.
- `busy` out 1: a load is in progress.
- `new_data` out 1: one-cycle start pulse to the systolic top.
- `load_error` out 1: sticky error flag; cleared on the next accepted `load_start`.
- `words_loaded` out 18: count of words written in the current or last load.

## Operation
- States: IDLE, CHECK, RX_HI, RX_LO, WRITE, DONE.
- **IDLE:** `load_start`=1 is accepted. On acceptance:
  - latch `addr_A`, `addr_B`, `n`;
  - compute nn = n*n (18-bit);
  - clear `load_error` and `words_loaded`;
  - go to CHECK.
- **CHECK** (1 cycle): declare an error if any of the following holds:
  - n==0;
  - `addr_A`+nn > 4096;
  - `addr_B`+nn > 4096;
  - regions [A, A+nn) and [B, B+nn) overlap.
  
  On error, set `load_error`=1 and go to IDLE. No writes occur and no `new_data` pulse is issued. Otherwise go to RX_HI.
- **Byte handshake:** a byte transfers only when `rx_valid` && `rx_ready`. `rx_ready` is 1 only in RX_HI and RX_LO.
- **RX_HI:** on transfer, store the byte as the high byte and go to RX_LO.
- **RX_LO:** on transfer, register `mem_data` = {hi, lo} and the address, then go to WRITE.
  - For word index k < nn: address = `addr_A` + k.
  - For k ≥ nn: address = `addr_B` + (k − nn).
  - Address arithmetic is 12-bit. It cannot wrap because of the CHECK rules.
- **WRITE** (1 cycle): `mem_wren`=1, `words_loaded` increments. If `words_loaded`+1 == 2*nn, go to DONE; else go to RX_HI.
- **DONE** (1 cycle): `new_data`=1, then go to IDLE.
- `busy`=1 in every state except IDLE.
- `load_start` outside IDLE is ignored; the latched parameters are unaffected.
- Byte order is big-endian, most significant byte first. Data is two's complement, passed through unmodified.

## Timing
- Reset values: `rx_ready`=0, `mem_addr`=0, `mem_data`=0, `mem_wren`=0, `busy`=0, `new_data`=0, `load_error`=0, `words_loaded`=0, state=IDLE.
- `rst` takes priority over all other inputs in the same cycle.
- Reset mid-load: all outputs take their reset values at that edge and any partial word is discarded. Words already written stay in memory, and no `new_data` pulse is issued.
- Per-cycle sequence from the accepting edge:
  - `busy`=1 from the cycle after `load_start` is accepted.
  - CHECK occupies that cycle; `rx_ready` rises the following cycle.
- With `rx_valid` held high, each word takes 3 cycles: hi, lo, write.
- Total load time with no stalls is 1 + 6*nn + 1 cycles after acceptance.
- `mem_addr`/`mem_data` are stable for the entire WRITE cycle, so the falling-edge memory captures them.
- `new_data` is high in exactly one cycle, immediately after the final WRITE cycle. `busy` drops in the same cycle that `new_data` falls.
- A `rx_valid` gap of any length stalls in RX_HI/RX_LO with no lost or duplicated bytes.

## Test plan
- **Basic load:** n=2, A=0x000, B=0x010, bytes 00 01 00 02 00 03 00 04 00 05 00 06 00 07 00 08.
  - Expect writes 0x0001..0x0004 at 0x000..0x003 and 0x0005..0x0008 at 0x010..0x013.
  - Expect exactly 8 `mem_wren` pulses, `words_loaded`=8, one `new_data` pulse 1 cycle after the last write, and `busy`=0 afterwards.
- **Backpressure:** same as basic load, but `rx_valid` is random 50% and held across WRITE. Expect identical memory contents and `rx_ready`=0 during every WRITE cycle.
- **Errors and bounds:**
  - n=0 gives `load_error`=1 two cycles after `load_start`, with no `mem_wren` and no `new_data`.
  - A=0x000, B=0x002, n=2 (overlap) gives an error.
  - A=0xFFC, B=0x000, n=2 is accepted; the last A write goes to 0xFFF.
  - A=0xFFD, n=2 gives an error.
- **Signed data:** bytes FF FE and 80 00 produce `mem_data` 0xFFFE (−2) and 0x8000 (−32768) unchanged.
- **Reset mid-operation:** assert `rst` after 3 words of an n=2 load. All outputs reach their reset values at the next edge. A subsequent fresh load with different data completes correctly and `words_loaded` restarts at 0.
- **Ignored start:** pulse `load_start` with n=3 during an n=2 load. Expect the load to complete with 8 words at the original addresses and `load_error` to remain 0.
